// File: rtl/frame_buffer_arbiter.sv
// frame_buffer_arbiter: N-way (2..4) frame buffer index manager between the
// camera-side writer and the HDMI-side reader, all on clk_100Mhz.
// The display vsync is synchronised and edge-detected; the detected edge
// drives the buffer swap in the same clock as the registered vsync_pulse,
// so vsync_pulse and swap_pulse are asserted together.
// Optional feature macro: FB_STATS_EN adds saturating drop/repeat/error counters.
module frame_buffer_arbiter #(
  parameter int                    NUM_BUFS    = 3,
  parameter int                    ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h1000_0000,
  parameter logic [ADDR_WIDTH-1:0] FRAME_BYTES = 32'h0009_6000,
  parameter int                    SYNC_STAGES = 2
) (
  input  logic                  clk_100Mhz,
  input  logic                  sys_rst_n,
  input  logic                  writer_done,
  input  logic                  vsync_in,
  output logic                  wr_buf_ready,
  output logic [1:0]            wr_buf_idx,
  output logic [ADDR_WIDTH-1:0] wr_base_addr,
  output logic [1:0]            rd_buf_idx,
  output logic [ADDR_WIDTH-1:0] rd_base_addr,
  output logic                  swap_pulse,
  output logic                  vsync_pulse
`ifdef FB_STATS_EN
  ,
  output logic [15:0]           frames_dropped,
  output logic [15:0]           frames_repeated,
  output logic [15:0]           done_errors
`endif
);

  if (NUM_BUFS < 2 || NUM_BUFS > 4) begin : g_bad_num_bufs
    $error("frame_buffer_arbiter: NUM_BUFS must be 2..4");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("frame_buffer_arbiter: SYNC_STAGES must be 2..4");
  end

  // Lowest buffer index that is neither x nor y.
  function automatic logic [1:0] free_idx(input logic [1:0] x, input logic [1:0] y);
    logic [1:0] r;
    r = 2'd0;
    for (int i = NUM_BUFS - 1; i >= 0; i--) begin
      if (2'(i) != x && 2'(i) != y) begin
        r = 2'(i);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // DDR base address of a buffer; product truncates to ADDR_WIDTH.
  function automatic logic [ADDR_WIDTH-1:0] buf_addr(input logic [1:0] idx);
    logic [ADDR_WIDTH-1:0] idx_w;
    idx_w = ADDR_WIDTH'(idx);
    return BASE_ADDR + idx_w * FRAME_BYTES;
  endfunction

  // Saturating 16-bit increment for the statistics counters.
  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    logic [15:0] r;
    if (en && v != 16'hFFFF) begin
      r = v + 16'd1;
    end else begin
      r = v;
    end
    return r;
  endfunction

  logic [1:0]             rst_sync_r;
  logic                   rst_n_s;
  logic [SYNC_STAGES-1:0] vsync_sync_r;
  logic                   vsync_prev_r;
  logic                   vsync_evt_s;
  logic [1:0]             pend_idx_r;
  logic                   pend_vld_r;
  logic                   done_acc_s;
  logic [1:0]             wr_idx_s;
  logic [1:0]             rd_idx_s;
  logic [1:0]             pend_idx_s;
  logic                   pend_vld_s;
  logic                   ready_s;
  logic                   swap_s;

  // Reset synchroniser: asynchronous assertion, release aligned to clk.
  always_ff @(posedge clk_100Mhz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign rst_n_s = rst_sync_r[1];

  // vsync_in synchroniser chain plus previous-value flop for edge detection.
  always_ff @(posedge clk_100Mhz or negedge rst_n_s) begin
    if (!rst_n_s) begin
      vsync_sync_r <= '0;
      vsync_prev_r <= 1'b0;
    end else begin
      vsync_sync_r <= {vsync_sync_r[SYNC_STAGES-2:0], vsync_in};
      vsync_prev_r <= vsync_sync_r[SYNC_STAGES-1];
    end
  end

  assign vsync_evt_s = vsync_sync_r[SYNC_STAGES-1] & ~vsync_prev_r;
  assign done_acc_s  = writer_done & wr_buf_ready;

  // Next buffer assignment from accepted writer_done and the vsync edge.
  always_comb begin
    wr_idx_s   = wr_buf_idx;
    rd_idx_s   = rd_buf_idx;
    pend_idx_s = pend_idx_r;
    pend_vld_s = pend_vld_r;
    ready_s    = wr_buf_ready;
    swap_s     = 1'b0;
    if (done_acc_s && vsync_evt_s) begin
      // Finished frame goes straight to the display.
      rd_idx_s   = wr_buf_idx;
      pend_vld_s = 1'b0;
      swap_s     = 1'b1;
      ready_s    = 1'b1;
      if (NUM_BUFS == 2) begin
        wr_idx_s = rd_buf_idx;
      end else if (pend_vld_r) begin
        wr_idx_s = free_idx(wr_buf_idx, pend_idx_r);
      end else begin
        wr_idx_s = free_idx(wr_buf_idx, rd_buf_idx);
      end
    end else if (done_acc_s) begin
      // Park the finished frame; an older pending frame is dropped.
      pend_idx_s = wr_buf_idx;
      pend_vld_s = 1'b1;
      if (NUM_BUFS == 2) begin
        ready_s = 1'b0;
      end else begin
        wr_idx_s = free_idx(rd_buf_idx, wr_buf_idx);
      end
    end else if (vsync_evt_s) begin
      if (pend_vld_r) begin
        rd_idx_s   = pend_idx_r;
        pend_vld_s = 1'b0;
        swap_s     = 1'b1;
        if (NUM_BUFS == 2) begin
          wr_idx_s = rd_buf_idx;
          ready_s  = 1'b1;
        end else begin
          wr_idx_s = wr_buf_idx;
        end
      end else begin
        swap_s = 1'b0;
      end
    end else begin
      swap_s = 1'b0;
    end
  end

  // Buffer state, addresses and pulses; address registered with its index.
  always_ff @(posedge clk_100Mhz or negedge rst_n_s) begin
    if (!rst_n_s) begin
      wr_buf_idx   <= 2'd0;
      rd_buf_idx   <= 2'd1;
      pend_idx_r   <= 2'd0;
      pend_vld_r   <= 1'b0;
      wr_buf_ready <= 1'b1;
      swap_pulse   <= 1'b0;
      vsync_pulse  <= 1'b0;
      wr_base_addr <= buf_addr(2'd0);
      rd_base_addr <= buf_addr(2'd1);
    end else begin
      wr_buf_idx   <= wr_idx_s;
      rd_buf_idx   <= rd_idx_s;
      pend_idx_r   <= pend_idx_s;
      pend_vld_r   <= pend_vld_s;
      wr_buf_ready <= ready_s;
      swap_pulse   <= swap_s;
      vsync_pulse  <= vsync_evt_s;
      wr_base_addr <= buf_addr(wr_idx_s);
      rd_base_addr <= buf_addr(rd_idx_s);
    end
  end

`ifdef FB_STATS_EN
  // Saturating drop / repeat / ignored-done counters.
  always_ff @(posedge clk_100Mhz or negedge rst_n_s) begin
    if (!rst_n_s) begin
      frames_dropped  <= 16'd0;
      frames_repeated <= 16'd0;
      done_errors     <= 16'd0;
    end else begin
      frames_dropped  <= sat_inc(frames_dropped, done_acc_s & pend_vld_r);
      frames_repeated <= sat_inc(frames_repeated, vsync_evt_s & ~pend_vld_r & ~done_acc_s);
      done_errors     <= sat_inc(done_errors, writer_done & ~wr_buf_ready);
    end
  end
`endif

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Directed bench for frame_buffer_arbiter: a triple-buffer instance (u3)
// and a double-buffer instance (u2) share clock and reset.
module tb_frame_buffer_arbiter;

  localparam logic [31:0] A0 = 32'h1000_0000;
  localparam logic [31:0] A1 = 32'h1009_6000;
  localparam logic [31:0] A2 = 32'h1012_C000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wd3 = 1'b0, vs3 = 1'b0, wd2 = 1'b0, vs2 = 1'b0;
  logic        rdy3, swp3, vp3, rdy2, swp2, vp2;
  logic [1:0]  wi3, ri3, wi2, ri2;
  logic [31:0] wa3, ra3, wa2, ra2;
`ifdef FB_STATS_EN
  logic [15:0] drp3, rep3, err3, drp2, rep2, err2;
`endif

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  frame_buffer_arbiter #(.NUM_BUFS(3)) u3 (
    .clk_100Mhz(clk), .sys_rst_n(rst_n), .writer_done(wd3), .vsync_in(vs3),
    .wr_buf_ready(rdy3), .wr_buf_idx(wi3), .wr_base_addr(wa3),
    .rd_buf_idx(ri3), .rd_base_addr(ra3), .swap_pulse(swp3), .vsync_pulse(vp3)
`ifdef FB_STATS_EN
    , .frames_dropped(drp3), .frames_repeated(rep3), .done_errors(err3)
`endif
  );

  frame_buffer_arbiter #(.NUM_BUFS(2)) u2 (
    .clk_100Mhz(clk), .sys_rst_n(rst_n), .writer_done(wd2), .vsync_in(vs2),
    .wr_buf_ready(rdy2), .wr_buf_idx(wi2), .wr_base_addr(wa2),
    .rd_buf_idx(ri2), .rd_base_addr(ra2), .swap_pulse(swp2), .vsync_pulse(vp2)
`ifdef FB_STATS_EN
    , .frames_dropped(drp2), .frames_repeated(rep2), .done_errors(err2)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tick();
  endtask

  // Let the synchroniser settle after vsync_in falls.
  task automatic flush();
    vs3 = 1'b0;
    vs2 = 1'b0;
    for (int i = 0; i < 5; i++) tick();
  endtask

  initial begin
    // Reset values
    do_reset();
    chk("rst_wr_idx", 32'(wi3), 32'd0);
    chk("rst_rd_idx", 32'(ri3), 32'd1);
    chk("rst_wr_addr", wa3, A0);
    chk("rst_rd_addr", ra3, A1);
    chk("rst_ready", 32'(rdy3), 32'd1);
    chk("rst_swap", 32'(swp3), 32'd0);
    chk("rst_vpulse", 32'(vp3), 32'd0);

    // N=3: writer_done then vsync high for 4 cycles
    wd3 = 1'b1; tick(); wd3 = 1'b0;
    chk("a_wr_idx", 32'(wi3), 32'd2);
    chk("a_wr_addr", wa3, A2);
    chk("a_rd_idx_hold", 32'(ri3), 32'd1);
    vs3 = 1'b1;
    tick();
    tick();
    chk("a_swap_early", 32'(swp3), 32'd0);
    tick();
    chk("a_swap", 32'(swp3), 32'd1);
    chk("a_vpulse", 32'(vp3), 32'd1);
    chk("a_rd_idx", 32'(ri3), 32'd0);
    chk("a_rd_addr", ra3, A0);
    tick();
    chk("a_swap_one_cycle", 32'(swp3), 32'd0);
    chk("a_vpulse_one_cycle", 32'(vp3), 32'd0);
    flush();

    // N=3: two frames before any vsync -> first dropped
    do_reset();
    wd3 = 1'b1; tick(); wd3 = 1'b0;
    tick();
    wd3 = 1'b1; tick(); wd3 = 1'b0;
    chk("b_wr_idx", 32'(wi3), 32'd0);
    chk("b_wr_addr", wa3, A0);
    chk("b_ready", 32'(rdy3), 32'd1);
    vs3 = 1'b1; tick(); tick(); tick();
    chk("b_rd_idx", 32'(ri3), 32'd2);
    chk("b_rd_addr", ra3, A2);
    flush();
`ifdef FB_STATS_EN
    chk("b_dropped", 32'(drp3), 32'd1);
    chk("b_repeated0", 32'(rep3), 32'd0);
`endif
    // vsync with nothing pending repeats the frame
    vs3 = 1'b1; tick(); tick(); tick();
    chk("b_repeat_swap", 32'(swp3), 32'd0);
    chk("b_repeat_vpulse", 32'(vp3), 32'd1);
    chk("b_repeat_rd", 32'(ri3), 32'd2);
    flush();
`ifdef FB_STATS_EN
    chk("b_repeated1", 32'(rep3), 32'd1);
`endif

    // N=3: writer_done in the same cycle as the vsync edge
    do_reset();
    vs3 = 1'b1; tick(); tick();
    wd3 = 1'b1; tick(); wd3 = 1'b0;
    chk("c_rd_idx", 32'(ri3), 32'd0);
    chk("c_wr_idx", 32'(wi3), 32'd2);
    chk("c_wr_addr", wa3, A2);
    chk("c_swap", 32'(swp3), 32'd1);
    chk("c_ready", 32'(rdy3), 32'd1);
    flush();
`ifdef FB_STATS_EN
    chk("c_repeated", 32'(rep3), 32'd0);
    chk("c_dropped", 32'(drp3), 32'd0);
`endif

    // N=2: stall until vsync, extra done ignored
    do_reset();
    wd2 = 1'b1; tick(); wd2 = 1'b0;
    chk("d_ready0", 32'(rdy2), 32'd0);
    chk("d_wr_hold", 32'(wi2), 32'd0);
    wd2 = 1'b1; tick(); wd2 = 1'b0;
    chk("d_ignored_wr", 32'(wi2), 32'd0);
    chk("d_ignored_rd", 32'(ri2), 32'd1);
    chk("d_ignored_ready", 32'(rdy2), 32'd0);
    vs2 = 1'b1; tick(); tick(); tick();
    chk("d_rd_idx", 32'(ri2), 32'd0);
    chk("d_wr_idx", 32'(wi2), 32'd1);
    chk("d_ready1", 32'(rdy2), 32'd1);
    chk("d_swap", 32'(swp2), 32'd1);
    chk("d_wr_addr", wa2, A1);
    chk("d_rd_addr", ra2, A0);
    flush();
`ifdef FB_STATS_EN
    chk("d_done_errors", 32'(err2), 32'd1);
`endif

    // Reset while a frame is pending: immediate return, pending lost
    do_reset();
    wd3 = 1'b1; tick(); wd3 = 1'b0;
    chk("e_pre_wr", 32'(wi3), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("e_async_wr", 32'(wi3), 32'd0);
    chk("e_async_rd", 32'(ri3), 32'd1);
    chk("e_async_wr_addr", wa3, A0);
    chk("e_async_ready", 32'(rdy3), 32'd1);
    wd3 = 1'b1; tick(); wd3 = 1'b0;
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    chk("e_done_lost", 32'(wi3), 32'd0);
    vs3 = 1'b1; tick(); tick(); tick();
    chk("e_no_swap", 32'(swp3), 32'd0);
    chk("e_rd_kept", 32'(ri3), 32'd1);
    flush();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
